ln_psum_router: RTL and testbench

- Parametrised local-network (LN) partial-sum router for the PE array.
- Sits between the PE grid, the ipsum GIN and the opsum GON. Decides per row whether a PE's opsum goes to the PE below it (LN chaining) or to the GON, and whether a PE's ipsum comes from the row above, the GIN, or a constant zero.
- Generalises the fixed 6x8 / depthwise-super-row wiring with these additions: parametric geometry and super-row period, buffered inter-row links, deferred config application, and a transfer counter.

---
 rtl/ln_psum_router_pkg.sv | 31 +++
 rtl/ln_psum_router_if.sv | 37 +++
 rtl/ln_psum_router_fifo.sv | 67 ++++++
 rtl/ln_psum_router.sv | 161 ++++++++++++++++
 tb/tb_ln_psum_router.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ln_psum_router_pkg.sv
// Shared geometry defaults, mode encoding and head-row helper for the LN psum router.
package ln_router_pkg;

    localparam int DEF_ROWS     = 6;
    localparam int DEF_COLS     = 8;
    localparam int N_PE         = DEF_ROWS * DEF_COLS;
    localparam int LINK_CNT     = (DEF_ROWS - 1) * DEF_COLS;

    typedef enum logic {
        MODE_NORMAL    = 1'b0,
        MODE_DEPTHWISE = 1'b1
    } mode_e;

    // PE count for an arbitrary geometry.
    function automatic int n_pe(input int rows, input int cols);
        return rows * cols;
    endfunction

    // Link count: one FIFO per column between each adjacent pair of rows.
    function automatic int link_cnt(input int rows, input int cols);
        return (rows - 1) * cols;
    endfunction

    // A head row starts a depthwise chain; the top row can never be fed from above.
    function automatic logic is_head_row(input int r, input logic depthwise,
                                         input int super_period = 3,
                                         input int num_rows = DEF_ROWS);
        return depthwise && (((r % super_period) == (super_period - 1)) || (r == num_rows - 1));
    endfunction

endpackage

// File: rtl/ln_psum_router_if.sv
// PE / GIN / GON psum handshake bundle seen by the LN router.
interface ln_psum_router_if #(
    parameter int NUMS_PE_ROW = 6,
    parameter int NUMS_PE_COL = 8,
    parameter int DATA_SIZE   = 32
);
    localparam int N = NUMS_PE_ROW * NUMS_PE_COL;

    logic [N*DATA_SIZE-1:0] pe_opsum;
    logic [N-1:0]           pe_opsum_valid;
    logic [N-1:0]           pe_opsum_ready;
    logic [N*DATA_SIZE-1:0] pe_ipsum;
    logic [N-1:0]           pe_ipsum_valid;
    logic [N-1:0]           pe_ipsum_ready;
    logic [DATA_SIZE-1:0]   gin_ipsum;
    logic [N-1:0]           gin_ipsum_valid;
    logic [N-1:0]           gin_ipsum_ready;
    logic [N-1:0]           gon_opsum_valid;
    logic [N-1:0]           gon_opsum_ready;

    // Router side.
    modport slave (
        input  pe_opsum, pe_opsum_valid, pe_ipsum_ready,
               gin_ipsum, gin_ipsum_valid, gon_opsum_ready,
        output pe_opsum_ready, pe_ipsum, pe_ipsum_valid,
               gin_ipsum_ready, gon_opsum_valid
    );

    // PE array / GIN / GON side.
    modport master (
        output pe_opsum, pe_opsum_valid, pe_ipsum_ready,
               gin_ipsum, gin_ipsum_valid, gon_opsum_ready,
        input  pe_opsum_ready, pe_ipsum, pe_ipsum_valid,
               gin_ipsum_ready, gon_opsum_valid
    );

endinterface

// File: rtl/ln_psum_router_fifo.sv
// Small inter-row link FIFO: no bypass, ready reflects occupancy before any same-cycle pop.
module psum_link_fifo #(
    parameter int DATA_SIZE  = 32,
    parameter int LINK_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_valid,
    output logic                 push_ready,
    input  logic [DATA_SIZE-1:0] push_data,
    output logic                 pop_valid,
    input  logic                 pop_ready,
    output logic [DATA_SIZE-1:0] pop_data
);
    localparam int PTR_W = (LINK_DEPTH > 1) ? $clog2(LINK_DEPTH) : 1;
    localparam int CNT_W = $clog2(LINK_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LINK_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LINK_DEPTH);

    logic [DATA_SIZE-1:0] mem_q [LINK_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 do_push, do_pop;

    assign push_ready = (cnt_q != FULL_CNT);
    assign pop_valid  = (cnt_q != '0);
    assign pop_data   = mem_q[rd_ptr_q];
    assign do_push    = push_valid & push_ready;
    assign do_pop     = pop_valid & pop_ready;

    // Next-state pointers and occupancy.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer/occupancy state; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; an entry is only observable once cnt_q counts it.
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ln_psum_router.sv
// LN partial-sum router: chains PE rows through link FIFOs or sends psums to GIN/GON.
module ln_psum_router
    import ln_router_pkg::*;
#(
    parameter int NUMS_PE_ROW  = 6,
    parameter int NUMS_PE_COL  = 8,
    parameter int DATA_SIZE    = 32,
    parameter int SUPER_PERIOD = 3,
    parameter int LINK_DEPTH   = 2,
    parameter int CNT_BITS     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_LN,
    input  logic [NUMS_PE_ROW-2:0] LN_config_in,
    input  logic                   set_mode,
    input  logic                   mode_in,
    input  logic                   cnt_clr,
    ln_psum_router_if.slave        bus,
    output logic                   busy,
    output logic                   config_pending,
    output logic [NUMS_PE_ROW-2:0] LN_config,
    output logic                   depthwise,
    output logic [CNT_BITS-1:0]    psum_tx_cnt
);
    localparam int N  = n_pe(NUMS_PE_ROW, NUMS_PE_COL);
    localparam int LC = link_cnt(NUMS_PE_ROW, NUMS_PE_COL);

    // Active and staged configuration.
    logic [NUMS_PE_ROW-2:0] ln_q, ln_d, ln_pend_q, ln_pend_d;
    mode_e                  mode_q, mode_d, mode_pend_q, mode_pend_d;
    logic                   ln_staged_q, ln_staged_d, mode_staged_q, mode_staged_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;

    logic [NUMS_PE_ROW-1:0] head_row;
    logic [NUMS_PE_ROW-2:0] link_en;

    // Link FIFO handshakes; link index l = r*COL + c feeds PE l from PE l+COL.
    logic [LC-1:0]        lk_push_valid, lk_push_ready;
    logic [LC-1:0]        lk_pop_valid, lk_pop_ready;
    logic [DATA_SIZE-1:0] lk_pop_data [LC];
    logic                 any_push, apply;

    assign LN_config      = ln_q;
    assign depthwise      = (mode_q == MODE_DEPTHWISE);
    assign config_pending = ln_staged_q | mode_staged_q;
    assign busy           = |lk_pop_valid;
    assign psum_tx_cnt    = cnt_q;
    assign any_push       = |(lk_push_valid & lk_push_ready);
    assign apply          = config_pending & ~busy & ~any_push;

    // Head rows and effective links from the active registers only.
    always_comb begin
        head_row = '0;
        link_en  = '0;
        for (int r = 0; r < NUMS_PE_ROW; r++)
            head_row[r] = is_head_row(r, depthwise, SUPER_PERIOD, NUMS_PE_ROW);
        for (int r = 0; r < NUMS_PE_ROW - 1; r++)
            link_en[r] = ln_q[r] & ~head_row[r];
    end

    // Config staging: apply when the links are idle, then re-stage any same-cycle set.
    always_comb begin
        ln_d          = ln_q;
        mode_d        = mode_q;
        ln_pend_d     = ln_pend_q;
        mode_pend_d   = mode_pend_q;
        ln_staged_d   = ln_staged_q;
        mode_staged_d = mode_staged_q;
        if (apply) begin
            if (ln_staged_q)   ln_d   = ln_pend_q;
            if (mode_staged_q) mode_d = mode_pend_q;
            ln_staged_d   = 1'b0;
            mode_staged_d = 1'b0;
        end
        if (set_LN) begin
            ln_pend_d   = LN_config_in;
            ln_staged_d = 1'b1;
        end
        if (set_mode) begin
            mode_pend_d   = mode_e'(mode_in);
            mode_staged_d = 1'b1;
        end
    end

    // GON transfer counter; clear wins over same-cycle handshakes.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N; i++)
            cnt_d = cnt_d + CNT_BITS'(bus.gon_opsum_valid[i] & bus.gon_opsum_ready[i]);
        if (cnt_clr) cnt_d = '0;
    end

    // Configuration and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ln_q          <= '0;
            mode_q        <= MODE_NORMAL;
            ln_pend_q     <= '0;
            mode_pend_q   <= MODE_NORMAL;
            ln_staged_q   <= 1'b0;
            mode_staged_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            ln_q          <= ln_d;
            mode_q        <= mode_d;
            ln_pend_q     <= ln_pend_d;
            mode_pend_q   <= mode_pend_d;
            ln_staged_q   <= ln_staged_d;
            mode_staged_q <= mode_staged_d;
            cnt_q         <= cnt_d;
        end
    end

    for (genvar l = 0; l < LC; l++) begin : g_link
        psum_link_fifo #(
            .DATA_SIZE  (DATA_SIZE),
            .LINK_DEPTH (LINK_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push_valid (lk_push_valid[l]),
            .push_ready (lk_push_ready[l]),
            .push_data  (bus.pe_opsum[(l+NUMS_PE_COL)*DATA_SIZE +: DATA_SIZE]),
            .pop_valid  (lk_pop_valid[l]),
            .pop_ready  (lk_pop_ready[l]),
            .pop_data   (lk_pop_data[l])
        );
    end

    for (genvar p = 0; p < N; p++) begin : g_pe
        localparam int R = p / NUMS_PE_COL;

        // Opsum: chain into the row below, or straight to the GON.
        if (R == 0) begin : g_op_gon
            assign bus.gon_opsum_valid[p] = bus.pe_opsum_valid[p];
            assign bus.pe_opsum_ready[p]  = bus.gon_opsum_ready[p];
        end else begin : g_op_sel
            assign lk_push_valid[p-NUMS_PE_COL] = link_en[R-1] & bus.pe_opsum_valid[p];
            assign bus.gon_opsum_valid[p]       = ~link_en[R-1] & bus.pe_opsum_valid[p];
            assign bus.pe_opsum_ready[p]        = link_en[R-1] ? lk_push_ready[p-NUMS_PE_COL]
                                                               : bus.gon_opsum_ready[p];
        end

        // Ipsum: link from the row above, zero at a depthwise head, else the GIN.
        if (R < NUMS_PE_ROW - 1) begin : g_ip_sel
            assign lk_pop_ready[p] = link_en[R] & bus.pe_ipsum_ready[p];
            assign bus.pe_ipsum[p*DATA_SIZE +: DATA_SIZE] =
                link_en[R] ? lk_pop_data[p] : (head_row[R] ? '0 : bus.gin_ipsum);
            assign bus.pe_ipsum_valid[p] =
                link_en[R] ? lk_pop_valid[p] : (head_row[R] | bus.gin_ipsum_valid[p]);
            assign bus.gin_ipsum_ready[p] =
                (link_en[R] | head_row[R]) ? 1'b0 : bus.pe_ipsum_ready[p];
        end else begin : g_ip_top
            assign bus.pe_ipsum[p*DATA_SIZE +: DATA_SIZE] = head_row[R] ? '0 : bus.gin_ipsum;
            assign bus.pe_ipsum_valid[p]  = head_row[R] | bus.gin_ipsum_valid[p];
            assign bus.gin_ipsum_ready[p] = head_row[R] ? 1'b0 : bus.pe_ipsum_ready[p];
        end
    end

endmodule

// File: tb/tb_ln_psum_router.sv
// Scoreboard bench for ln_psum_router at the default 6x8 geometry.
module tb_ln_psum_router;
    localparam int ROW = 6;
    localparam int COL = 8;
    localparam int D   = 32;
    localparam int N   = ROW * COL;
    localparam int CB  = 16;

    typedef struct {
        int         pe;
        logic [D-1:0] data;
    } sb_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           set_LN, set_mode, mode_in, cnt_clr;
    logic [ROW-2:0] LN_config_in;
    logic           busy, config_pending, depthwise;
    logic [ROW-2:0] LN_config;
    logic [CB-1:0]  psum_tx_cnt;

    ln_psum_router_if #(.NUMS_PE_ROW(ROW), .NUMS_PE_COL(COL), .DATA_SIZE(D)) bus ();

    ln_psum_router #(
        .NUMS_PE_ROW(ROW), .NUMS_PE_COL(COL), .DATA_SIZE(D),
        .SUPER_PERIOD(3), .LINK_DEPTH(2), .CNT_BITS(CB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .set_LN         (set_LN),
        .LN_config_in   (LN_config_in),
        .set_mode       (set_mode),
        .mode_in        (mode_in),
        .cnt_clr        (cnt_clr),
        .bus            (bus),
        .busy           (busy),
        .config_pending (config_pending),
        .LN_config      (LN_config),
        .depthwise      (depthwise),
        .psum_tx_cnt    (psum_tx_cnt)
    );

    always #5 clk = ~clk;

    int       n_cmp = 0;
    int       n_err = 0;
    sb_t      sb_q[$];
    logic [ROW-2:0] m_ln = '0;
    logic     m_dw = 1'b0;
    logic [N-1:0] exp_v;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bench-side view of which row boundaries are chained.
    function automatic logic m_link(input int r);
        logic head;
        if (r < 0 || r >= ROW - 1) return 1'b0;
        head = m_dw && (((r % 3) == 2) || (r == ROW - 1));
        return m_ln[r] && !head;
    endfunction

    // Compare link-sourced ipsum handshakes, record accepted pushes, advance one cycle.
    task automatic tick();
        #1;
        for (int p = 0; p < N; p++) begin
            int  r;
            sb_t e;
            r = p / COL;
            if (m_link(r) && bus.pe_ipsum_valid[p] && bus.pe_ipsum_ready[p]) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected", 64'(sb_q.size()), 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_pe", 64'(p), 64'(e.pe));
                    check("sb_data", 64'(bus.pe_ipsum[p*D +: D]), 64'(e.data));
                end
            end
        end
        for (int p = COL; p < N; p++) begin
            if (m_link(p / COL - 1) && bus.pe_opsum_valid[p] && bus.pe_opsum_ready[p])
                sb_q.push_back('{pe: p - COL, data: bus.pe_opsum[p*D +: D]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check("drain_left", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic apply_cfg(input logic [ROW-2:0] ln, input logic mode);
        set_LN = 1'b1; LN_config_in = ln; set_mode = 1'b1; mode_in = mode;
        tick();
        set_LN = 1'b0; set_mode = 1'b0;
        tick();
        m_ln = ln; m_dw = mode;
        check("cfg_ln", 64'(LN_config), 64'(ln));
        check("cfg_mode", 64'(depthwise), 64'(mode));
        check("cfg_pend", 64'(config_pending), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_LN = 1'b0; set_mode = 1'b0; mode_in = 1'b0; cnt_clr = 1'b0; LN_config_in = '0;
        bus.pe_opsum = '0; bus.pe_opsum_valid = '0; bus.pe_ipsum_ready = '0;
        bus.gin_ipsum = '0; bus.gin_ipsum_valid = '0; bus.gon_opsum_ready = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_ln", 64'(LN_config), 64'd0);
        check("rst_dw", 64'(depthwise), 64'd0);
        check("rst_pend", 64'(config_pending), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cnt", 64'(psum_tx_cnt), 64'd0);
        check("rst_ipv", 64'(bus.pe_ipsum_valid), 64'd0);

        // Normal mode, rows 0..2 chained: one psum per PE.
        apply_cfg(5'b00011, 1'b0);
        bus.gon_opsum_ready = '1;
        for (int p = 0; p < N; p++) begin
            bus.pe_opsum[p*D +: D] = D'(100 * (p / COL) + (p % COL));
            exp_v[p] = ((p / COL) == 0) || ((p / COL) >= 3);
        end
        bus.pe_opsum_valid = '1;
        #1;
        check("t1_gon_v", 64'(bus.gon_opsum_valid), 64'(exp_v));
        check("t1_op_rdy", 64'(bus.pe_opsum_ready), 64'(48'hFFFF_FFFF_FFFF));
        check("t1_nobypass", 64'(bus.pe_ipsum_valid[11]), 64'd0);
        tick();
        bus.pe_opsum_valid = '0;
        #1;
        check("t1_ip_v_11", 64'(bus.pe_ipsum_valid[11]), 64'd1);
        check("t1_ip_d_11", 64'(bus.pe_ipsum[11*D +: D]), 64'd203);
        check("t1_cnt", 64'(psum_tx_cnt), 64'd32);
        bus.pe_ipsum_ready = '1;
        drain(10);

        // Backpressure on link L[0][0] with depth 2.
        bus.pe_ipsum_ready = '0;
        bus.pe_opsum_valid[8] = 1'b1;
        bus.pe_opsum[8*D +: D] = 32'd10;
        #1 check("bp_rdy0", 64'(bus.pe_opsum_ready[8]), 64'd1);
        tick();
        bus.pe_opsum[8*D +: D] = 32'd11;
        #1 check("bp_rdy1", 64'(bus.pe_opsum_ready[8]), 64'd1);
        tick();
        bus.pe_opsum[8*D +: D] = 32'd12;
        #1 check("bp_full", 64'(bus.pe_opsum_ready[8]), 64'd0);
        tick();
        check("bp_full_hold", 64'(bus.pe_opsum_ready[8]), 64'd0);
        bus.pe_ipsum_ready[0] = 1'b1;
        #1 check("bp_full_pop", 64'(bus.pe_opsum_ready[8]), 64'd0);
        tick();
        tick();
        bus.pe_opsum_valid[8] = 1'b0;
        drain(10);
        check("bp_busy", 64'(busy), 64'd0);

        // Depthwise with all links requested: heads at rows 2 and 5.
        bus.pe_ipsum_ready = '0;
        apply_cfg(5'b11111, 1'b1);
        bus.gin_ipsum = 32'hABCD;
        bus.gin_ipsum_valid = '1;
        bus.pe_ipsum_ready = '1;
        bus.pe_opsum_valid = '0;
        bus.pe_opsum_valid[24 +: 16] = 16'hFFFF;
        #1;
        check("dw_ipv_r2", 64'(bus.pe_ipsum_valid[16 +: 8]), 64'hFF);
        check("dw_ipv_r5", 64'(bus.pe_ipsum_valid[40 +: 8]), 64'hFF);
        check("dw_ipd_r2", 64'(bus.pe_ipsum[16*D +: D]), 64'd0);
        check("dw_ipd_r5", 64'(bus.pe_ipsum[47*D +: D]), 64'd0);
        check("dw_ipv_r0", 64'(bus.pe_ipsum_valid[0 +: 8]), 64'h00);
        check("dw_gin_rdy", 64'(bus.gin_ipsum_ready), 64'd0);
        check("dw_gon_v", 64'(bus.gon_opsum_valid), 64'(48'h0000_FF00_0000));
        check("dw_op_rdy3", 64'(bus.pe_opsum_ready[24 +: 8]), 64'hFF);
        bus.pe_opsum_valid = '0;
        bus.gin_ipsum_valid = '0;
        bus.pe_ipsum_ready = '0;
        tick();

        // Deferred config while a word is buffered, plus re-stage in the apply cycle.
        apply_cfg(5'b00011, 1'b0);
        bus.pe_opsum_valid[8] = 1'b1;
        bus.pe_opsum[8*D +: D] = 32'd77;
        tick();
        bus.pe_opsum_valid[8] = 1'b0;
        set_LN = 1'b1; LN_config_in = 5'b00001;
        tick();
        set_LN = 1'b0;
        check("cp_pend", 64'(config_pending), 64'd1);
        check("cp_ln_hold", 64'(LN_config), 64'b00011);
        check("cp_busy", 64'(busy), 64'd1);
        bus.pe_ipsum_ready[0] = 1'b1;
        tick();
        check("cp_busy_clr", 64'(busy), 64'd0);
        check("cp_pend_hold", 64'(config_pending), 64'd1);
        check("cp_ln_hold2", 64'(LN_config), 64'b00011);
        set_mode = 1'b1; mode_in = 1'b1;
        tick();
        set_mode = 1'b0;
        m_ln = 5'b00001;
        check("cp_ln_new", 64'(LN_config), 64'b00001);
        check("cp_restage", 64'(config_pending), 64'd1);
        check("cp_dw_old", 64'(depthwise), 64'd0);
        tick();
        m_dw = 1'b1;
        check("cp_dw_new", 64'(depthwise), 64'd1);
        check("cp_ln_kept", 64'(LN_config), 64'b00001);
        check("cp_pend_clr", 64'(config_pending), 64'd0);
        bus.pe_ipsum_ready = '0;

        // Counter wrap and clear priority, everything to the GON.
        apply_cfg(5'b00000, 1'b0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("cnt_clr0", 64'(psum_tx_cnt), 64'd0);
        bus.gon_opsum_ready = '1;
        bus.pe_opsum_valid = '1;
        repeat (1365) tick();
        check("cnt_fff0", 64'(psum_tx_cnt), 64'hFFF0);
        bus.pe_opsum_valid = 48'h7FFF;
        tick();
        check("cnt_ffff", 64'(psum_tx_cnt), 64'hFFFF);
        bus.pe_opsum_valid = 48'h3;
        tick();
        check("cnt_wrap", 64'(psum_tx_cnt), 64'h0001);
        bus.pe_opsum_valid = 48'h7;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        bus.pe_opsum_valid = '0;
        check("cnt_clr_prio", 64'(psum_tx_cnt), 64'd0);
        tick();
        check("cnt_idle", 64'(psum_tx_cnt), 64'd0);

        // Reset with two words buffered.
        apply_cfg(5'b00011, 1'b0);
        bus.pe_opsum_valid[8] = 1'b1;
        bus.pe_opsum[8*D +: D] = 32'd5;
        tick();
        bus.pe_opsum[8*D +: D] = 32'd6;
        tick();
        bus.pe_opsum_valid[8] = 1'b0;
        #1;
        check("rr_v_before", 64'(bus.pe_ipsum_valid[0]), 64'd1);
        check("rr_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("rr_v_async", 64'(bus.pe_ipsum_valid[0]), 64'd0);
        check("rr_busy", 64'(busy), 64'd0);
        check("rr_ln", 64'(LN_config), 64'd0);
        sb_q.delete();
        m_ln = '0; m_dw = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.pe_ipsum_ready = '1;
        tick();
        tick();
        apply_cfg(5'b00011, 1'b0);
        #1;
        check("rr_no_stale", 64'(bus.pe_ipsum_valid[0]), 64'd0);
        check("rr_busy_after", 64'(busy), 64'd0);
        tick();

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
